// File: rtl/dmem_wait_sram.sv
// rtl/dmem_wait_sram.sv - word-organised data memory with a fixed request-to-ready latency
module dmem_wait_sram #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_read_i,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    protocol_err_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            count;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  strobe;
  logic                  accept;
  logic                  commit;
  logic                  enter_read;
  logic [IDX_W-1:0]      idx_in;
  logic [IDX_W-1:0]      ridx;
  logic [DATA_WIDTH-1:0] rword;
  logic                  unused_addr;

  assign strobe      = req_read_i | req_write_i;
  assign accept      = strobe && (state != S_BUSY);
  assign commit      = (state == S_RESP) && write_q;
  assign idx_in      = addr_i[OFF_W +: IDX_W];
  assign unused_addr = ^addr_i;

  // With LATENCY=1 a read enters RESP on its own strobe edge, so it indexes from the live address.
  assign enter_read = (LATENCY == 1) ? (accept && !req_write_i)
                                     : (state == S_BUSY && count == 4'd1 && !write_q);
  assign ridx       = (LATENCY == 1) ? idx_in : idx_q;

  // A write committing on the same edge the read samples must be visible to that read.
  always_comb begin
    rword = mem[ridx];
    if (commit && idx_q == ridx) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) rword[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      count          <= 4'd0;
      idx_q          <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      write_q        <= 1'b0;
      rdata_o        <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (strobe && (state == S_BUSY || (req_read_i && req_write_i))) protocol_err_o <= 1'b1;
      if (enter_read) rdata_o <= rword;
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            idx_q   <= idx_in;
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
            write_q <= req_write_i;
            count   <= LAT_M1;
            state   <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign ready_o = (state == S_RESP);
  assign busy_o  = (state == S_BUSY);

endmodule
